// File: rtl/dbg_pkg.sv
// Shared types and widths for the register-file debug dump path.
package dbg_pkg;

    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CAPTURE,
        SEND,
        DONE
    } state_e;

    // Byte at position pos of a frame: optional index byte, then word MSB-first.
    function automatic logic [BYTE_W-1:0] frame_byte(
        input logic [WORD_W-1:0]    word,
        input logic [REG_IDX_W-1:0] idx,
        input logic [2:0]           pos,
        input bit                   send_index
    );
        logic [2:0]        wpos;
        logic [BYTE_W-1:0] b;
        wpos = send_index ? (pos - 3'd1) : pos;
        case (wpos)
            3'd0:    b = word[31:24];
            3'd1:    b = word[23:16];
            3'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        if (send_index && (pos == 3'd0)) begin
            b = {3'b000, idx};
        end
        return b;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Emits one captured register word (plus optional index byte) MSB-first over valid/ready.
module word_serializer
    import dbg_pkg::*;
#(
    parameter int SEND_INDEX = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [WORD_W-1:0]    word_i,
    input  logic [REG_IDX_W-1:0] idx_i,
    input  logic                 stop_i,
    input  logic                 tx_ready_i,
    output logic [BYTE_W-1:0]    tx_data_o,
    output logic                 tx_valid_o,
    output logic                 accept_o,
    output logic                 last_o
);

    localparam bit         SEND_IDX_B = (SEND_INDEX != 0);
    localparam logic [2:0] LAST_POS   = SEND_IDX_B ? 3'd4 : 3'd3;

    logic [WORD_W-1:0]    word_q,  word_d;
    logic [REG_IDX_W-1:0] idx_q,   idx_d;
    logic [2:0]           cnt_q,   cnt_d;
    logic [BYTE_W-1:0]    data_q,  data_d;
    logic                 valid_q, valid_d;
    logic                 hs;

    assign hs = valid_q && tx_ready_i;

    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            word_d  = word_i;
            idx_d   = idx_i;
            cnt_d   = '0;
            valid_d = 1'b1;
            data_d  = frame_byte(word_i, idx_i, 3'd0, SEND_IDX_B);
        end else if (hs) begin
            // A pending stop ends the frame at this handshake; data is left as-is.
            if ((cnt_q == LAST_POS) || stop_i) begin
                valid_d = 1'b0;
            end else begin
                cnt_d  = cnt_q + 3'd1;
                data_d = frame_byte(word_q, idx_q, cnt_q + 3'd1, SEND_IDX_B);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;
    assign accept_o   = hs;
    assign last_o     = hs && (cnt_q == LAST_POS);

endmodule

// File: rtl/rf_dump_reader.sv
// Debug dump master: walks the register file debug port and streams each register as bytes.
module rf_dump_reader
    import dbg_pkg::*;
#(
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = 31,
    parameter int SEND_INDEX = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 cpu_hold,
    output logic [REG_IDX_W-1:0] reg_sel,
    input  logic [WORD_W-1:0]    reg_data,
    output logic [BYTE_W-1:0]    tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready
);

    localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

    state_e               state_q, state_d;
    logic [REG_IDX_W-1:0] sel_q,   sel_d;
    logic                 pend_q,  pend_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 load;
    logic                 stop;
    logic                 ser_accept;
    logic                 ser_last;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        load    = 1'b0;
        stop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (start) begin
                    sel_d   = FIRST_IDX;
                    state_d = SELECT;
                end
            end
            SELECT: state_d = abort ? IDLE : CAPTURE;
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Abort is remembered until the byte on the wire has been taken.
                stop = abort || pend_q;
                if (abort) begin
                    pend_d = 1'b1;
                end
                if (ser_accept && stop) begin
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end else if (ser_last) begin
                    if (sel_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        sel_d   = sel_q + 1'b1;
                        state_d = SELECT;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= FIRST_IDX;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    word_serializer #(
        .SEND_INDEX(SEND_INDEX)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .word_i     (reg_data),
        .idx_i      (sel_q),
        .stop_i     (stop),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .accept_o   (ser_accept),
        .last_o     (ser_last)
    );

    assign busy     = busy_q;
    assign cpu_hold = busy_q;
    assign done     = done_q;
    assign reg_sel  = sel_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader: default config plus a narrow no-index config.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0, abort_a = 1'b0, rdy_a = 1'b1;
    logic        busy_a, done_a, hold_a, txv_a;
    logic [4:0]  sel_a;
    logic [31:0] rdata_a;
    logic [7:0]  txd_a;

    logic        start_b = 1'b0, abort_b = 1'b0, rdy_b = 1'b1;
    logic        busy_b, done_b, hold_b, txv_b;
    logic [4:0]  sel_b;
    logic [31:0] rdata_b;
    logic [7:0]  txd_b;

    logic [31:0] rf_a [32];
    logic [31:0] rf_b [32];
    logic [7:0]  cap_a [$];
    logic [7:0]  cap_b [$];
    logic [7:0]  exp_q [$];
    logic [7:0]  first_run [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural register file debug port: combinational, register 0 reads zero.
    assign rdata_a = (sel_a == 5'd0) ? 32'h0 : rf_a[sel_a];
    assign rdata_b = (sel_b == 5'd0) ? 32'h0 : rf_b[sel_b];

    rf_dump_reader u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .cpu_hold(hold_a), .reg_sel(sel_a),
        .reg_data(rdata_a), .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(rdy_a)
    );

    rf_dump_reader #(.FIRST_REG(3), .LAST_REG(4), .SEND_INDEX(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .cpu_hold(hold_b), .reg_sel(sel_b),
        .reg_data(rdata_b), .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(rdy_b)
    );

    always @(negedge clk) begin
        if (txv_a && rdy_a) cap_a.push_back(txd_a);
        if (txv_b && rdy_b) cap_b.push_back(txd_b);
    end

    // Reference frame: for each register in range, optional index byte then value big-endian.
    function automatic void build_exp(input int first, input int last, input int sidx,
                                      input logic [31:0] rf [32]);
        logic [31:0] v;
        exp_q.delete();
        for (int r = first; r <= last; r++) begin
            if (sidx != 0) exp_q.push_back(8'(r));
            v = (r == 0) ? 32'h0 : rf[r];
            for (int k = 3; k >= 0; k--) exp_q.push_back(v[k*8 +: 8]);
        end
    endfunction

    task automatic preload_plan();
        for (int i = 0; i < 32; i++) rf_a[i] = 32'(i);
        rf_a[1]  = 32'h12345678;
        rf_a[31] = 32'hDEADBEEF;
    endtask

    task automatic randomize_rf_a();
        for (int i = 0; i < 32; i++) rf_a[i] = $urandom;
    endtask

    // Runs one dump on DUT A. mode 0: ready=1; 1: random ready with a 20-cycle stall; 2: re-pulse start mid-dump.
    task automatic drive_dump_a(input int mode, output int done_cyc, output int first_v,
                                output int stall_bad, output int stalls,
                                output bit busy_at_done, output bit busy_after);
        int   cyc;
        int   stuck;
        bit   prev_stall;
        logic [7:0] prev_d;
        cap_a.delete();
        done_cyc = -1; first_v = -1; stall_bad = 0; stalls = 0;
        busy_at_done = 1'b0; busy_after = 1'b1;
        stuck = 20; prev_stall = 1'b0; prev_d = '0;
        @(posedge clk); #1;
        start_a = 1'b1;
        rdy_a   = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cyc = 0;
        while (cyc < 3000 && done_cyc < 0) begin
            @(negedge clk);
            if (prev_stall) begin
                stalls++;
                if (!txv_a || txd_a !== prev_d) stall_bad++;
            end
            prev_stall = txv_a && !rdy_a;
            prev_d     = txd_a;
            if (txv_a && first_v < 0) first_v = cyc;
            if (done_a) begin
                done_cyc     = cyc;
                busy_at_done = busy_a && hold_a;
            end
            @(posedge clk); cyc++;
            #1;
            if (mode == 1) begin
                if (cap_a.size() >= 52 && stuck > 0) begin
                    rdy_a = 1'b0;
                    stuck--;
                end else begin
                    rdy_a = 1'($urandom_range(0, 1));
                end
            end
            start_a = (mode == 2 && (cyc == 50 || cyc == 120)) ? 1'b1 : 1'b0;
        end
        busy_after = busy_a || hold_a || done_a;
        start_a = 1'b0;
        rdy_a   = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (busy_a !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
        checks++; if (hold_a !== 1'b0)   begin errors++; $display("FAIL reset_hold: got %b expected 0", hold_a); end
        checks++; if (txv_a !== 1'b0)    begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", txv_a); end
        checks++; if (txd_a !== 8'h00)   begin errors++; $display("FAIL reset_tx_data: got %h expected 00", txd_a); end
        checks++; if (sel_a !== 5'd0)    begin errors++; $display("FAIL reset_reg_sel_a: got %0d expected 0", sel_a); end
        checks++; if (sel_b !== 5'd3)    begin errors++; $display("FAIL reset_reg_sel_b: got %0d expected 3", sel_b); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_full_dump();
        int dc, fv, sb, st;
        bit bd, ba;
        preload_plan();
        build_exp(0, 31, 1, rf_a);
        drive_dump_a(0, dc, fv, sb, st, bd, ba);
        checks++; if (fv !== 2)   begin errors++; $display("FAIL full_first_valid: got cycle %0d expected 2", fv); end
        checks++; if (dc !== 224) begin errors++; $display("FAIL full_done_cycle: got %0d expected 224", dc); end
        checks++; if (bd !== 1'b1) begin errors++; $display("FAIL full_busy_at_done: got %b expected 1", bd); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL full_busy_after: got %b expected 0", ba); end
        checks++; if (cap_a.size() != 160) begin errors++; $display("FAIL full_count: got %0d expected 160", cap_a.size()); end
        if (cap_a.size() == 160) begin
            checks++; if (cap_a[5] !== 8'h01)   begin errors++; $display("FAIL full_byte5: got %h expected 01", cap_a[5]); end
            checks++; if (cap_a[6] !== 8'h12)   begin errors++; $display("FAIL full_byte6: got %h expected 12", cap_a[6]); end
            checks++; if (cap_a[155] !== 8'h1F) begin errors++; $display("FAIL full_byte155: got %h expected 1F", cap_a[155]); end
            checks++; if (cap_a[159] !== 8'hEF) begin errors++; $display("FAIL full_byte159: got %h expected EF", cap_a[159]); end
            for (int i = 0; i < 160; i++) begin
                checks++;
                if (cap_a[i] !== exp_q[i]) begin errors++; $display("FAIL full_byte[%0d]: got %h expected %h", i, cap_a[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int dc, fv, sb, st;
        bit bd, ba;
        preload_plan();
        build_exp(0, 31, 1, rf_a);
        drive_dump_a(1, dc, fv, sb, st, bd, ba);
        checks++; if (dc < 224) begin errors++; $display("FAIL bp_done: got cycle %0d expected >=224", dc); end
        checks++; if (st < 20)  begin errors++; $display("FAIL bp_stalls_seen: got %0d expected >=20", st); end
        checks++; if (sb !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changed cycles expected 0", sb); end
        checks++; if (cap_a.size() != 160) begin errors++; $display("FAIL bp_count: got %0d expected 160", cap_a.size()); end
        if (cap_a.size() == 160) begin
            for (int i = 0; i < 160; i++) begin
                checks++;
                if (cap_a[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte[%0d]: got %h expected %h", i, cap_a[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_small_range();
        int  cyc, dc, fv;
        for (int i = 0; i < 32; i++) rf_b[i] = $urandom;
        rf_b[3] = 32'hA5A5A5A5;
        rf_b[4] = 32'h0F0F0F0F;
        build_exp(3, 4, 0, rf_b);
        cap_b.delete();
        dc = -1; fv = -1;
        @(posedge clk); #1; start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        cyc = 0;
        while (cyc < 200 && dc < 0) begin
            @(negedge clk);
            if (txv_b && fv < 0) fv = cyc;
            if (done_b) dc = cyc;
            @(posedge clk); cyc++; #1;
        end
        checks++; if (fv !== 2)  begin errors++; $display("FAIL small_first_valid: got %0d expected 2", fv); end
        checks++; if (dc !== 12) begin errors++; $display("FAIL small_done_cycle: got %0d expected 12", dc); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL small_busy_after: got %b expected 0", busy_b); end
        checks++; if (cap_b.size() != 8) begin errors++; $display("FAIL small_count: got %0d expected 8", cap_b.size()); end
        if (cap_b.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (cap_b[i] !== exp_q[i]) begin errors++; $display("FAIL small_byte[%0d]: got %h expected %h", i, cap_b[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_abort();
        int  guard;
        bit  saw_valid, saw_done, saw_busy, held_ok;
        randomize_rf_a();
        build_exp(0, 31, 1, rf_a);
        cap_a.delete();
        rdy_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        guard = 0;
        while (cap_a.size() != 27 && guard < 500) begin
            @(posedge clk); #1; guard++;
        end
        checks++; if (guard >= 500) begin errors++; $display("FAIL abort_reach_r5: got %0d bytes expected 27", cap_a.size()); end
        rdy_a = 1'b0; abort_a = 1'b1;
        held_ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (!txv_a || txd_a !== exp_q[27]) held_ok = 1'b0;
            @(posedge clk); #1;
            abort_a = 1'b0;
        end
        checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL abort_hold: got valid %b data %h expected 1 %h", txv_a, txd_a, exp_q[27]); end
        rdy_a = 1'b1;
        @(posedge clk); #1;
        saw_valid = 1'b0; saw_done = 1'b0; saw_busy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            saw_valid |= txv_a; saw_done |= done_a; saw_busy |= busy_a;
        end
        checks++; if (saw_valid) begin errors++; $display("FAIL abort_no_more_valid: got 1 expected 0"); end
        checks++; if (saw_done)  begin errors++; $display("FAIL abort_no_done: got 1 expected 0"); end
        checks++; if (saw_busy)  begin errors++; $display("FAIL abort_idle: got busy 1 expected 0"); end
        checks++; if (cap_a.size() != 28) begin errors++; $display("FAIL abort_count: got %0d expected 28", cap_a.size()); end
        if (cap_a.size() == 28) begin
            checks++; if (cap_a[27] !== exp_q[27]) begin errors++; $display("FAIL abort_last_byte: got %h expected %h", cap_a[27], exp_q[27]); end
        end
    endtask

    task automatic test_back_to_back();
        int dc, fv, sb, st;
        bit bd, ba;
        randomize_rf_a();
        build_exp(0, 31, 1, rf_a);
        drive_dump_a(2, dc, fv, sb, st, bd, ba);
        checks++; if (dc !== 224) begin errors++; $display("FAIL restart_done_cycle: got %0d expected 224", dc); end
        checks++; if (cap_a.size() != 160) begin errors++; $display("FAIL restart_count: got %0d expected 160", cap_a.size()); end
        first_run = cap_a;
        drive_dump_a(0, dc, fv, sb, st, bd, ba);
        checks++; if (dc !== 224) begin errors++; $display("FAIL repeat_done_cycle: got %0d expected 224", dc); end
        checks++; if (cap_a.size() != 160) begin errors++; $display("FAIL repeat_count: got %0d expected 160", cap_a.size()); end
        if (cap_a.size() == 160 && first_run.size() == 160) begin
            for (int i = 0; i < 160; i++) begin
                checks++;
                if (cap_a[i] !== exp_q[i] || first_run[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL repeat_byte[%0d]: got %h/%h expected %h", i, first_run[i], cap_a[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_send();
        int dc, fv, sb, st, guard;
        bit bd, ba;
        randomize_rf_a();
        build_exp(0, 31, 1, rf_a);
        cap_a.delete();
        rdy_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        guard = 0;
        while (!(cap_a.size() >= 12 && txv_a) && guard < 500) begin
            @(posedge clk); #1; guard++;
        end
        checks++; if (!txv_a) begin errors++; $display("FAIL rst_mid_reach_send: got valid 0 expected 1"); end
        #1; rst = 1'b1;
        #1;
        checks++; if (txv_a !== 1'b0)  begin errors++; $display("FAIL rst_mid_tx_valid: got %b expected 0", txv_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy_a); end
        checks++; if (hold_a !== 1'b0) begin errors++; $display("FAIL rst_mid_hold: got %b expected 0", hold_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", done_a); end
        checks++; if (sel_a !== 5'd0)  begin errors++; $display("FAIL rst_mid_reg_sel: got %0d expected 0", sel_a); end
        @(posedge clk); #1; rst = 1'b0;
        drive_dump_a(0, dc, fv, sb, st, bd, ba);
        checks++; if (dc !== 224) begin errors++; $display("FAIL rst_after_done_cycle: got %0d expected 224", dc); end
        checks++; if (cap_a.size() != 160) begin errors++; $display("FAIL rst_after_count: got %0d expected 160", cap_a.size()); end
        if (cap_a.size() == 160) begin
            for (int i = 0; i < 160; i++) begin
                checks++;
                if (cap_a[i] !== exp_q[i]) begin errors++; $display("FAIL rst_after_byte[%0d]: got %h expected %h", i, cap_a[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        preload_plan();
        for (int i = 0; i < 32; i++) rf_b[i] = 32'(i);
        test_reset();
        test_full_dump();
        test_backpressure();
        test_small_range();
        test_abort();
        test_back_to_back();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
- Debug read-side master for the CPU register file's debug port: drives reg_sel, samples reg_data, and streams register contents out as a byte stream over a valid/ready handshake.
- Consumed downstream by the board UART transmitter or the trace FIFO.
- Asserts cpu_hold while dumping so the CPU can stall and the dump is a consistent snapshot.
- Sits beside the single-cycle CPU top; the register file's debug port is combinational (reg_data follows reg_sel in the same cycle; register 0 reads 0).

Parameters:
- FIRST_REG, 0, first register index dumped (0..31).
- LAST_REG, 31, last register index dumped (FIRST_REG..31).
- SEND_INDEX, 1, 1 = prefix each word with an index byte; 0 = data bytes only.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to begin a dump; ignored while busy.
- abort  input  1  cancel the dump in progress.
- busy  output  1  high from the cycle after start is accepted until the return to IDLE.
- done  output  1  one-cycle pulse when a dump completes normally.
- cpu_hold  output  1  stall request to the CPU; equals busy.
- reg_sel  output  5  register index driven to the register file debug port.
- reg_data  input  32  register value returned for reg_sel.
- tx_data  output  8  byte out.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  sink accepts the byte when tx_valid && tx_ready at posedge.

Behaviour:
- Reset values (async, any state): state=IDLE, busy=0, done=0, cpu_hold=0, tx_valid=0, tx_data=0, reg_sel=FIRST_REG, byte counter 0, captured word 0.
- States: IDLE, SELECT, CAPTURE, SEND, DONE. All outputs are registered.
- IDLE: if start, load reg_sel=FIRST_REG and go to SELECT.
- SELECT: one settle cycle, then go to CAPTURE.
- CAPTURE: latch reg_data into word, clear byte_cnt, go to SEND.
- SEND: tx_valid=1.
  - Byte order with SEND_INDEX=1: {3'b000, reg_sel}, word[31:24], word[23:16], word[15:8], word[7:0]. With SEND_INDEX=0 the index byte is omitted. NBYTES = 4 + SEND_INDEX.
  - tx_data and tx_valid hold stable while tx_valid && !tx_ready. tx_valid never drops without a handshake.
  - On a handshake of the last byte: if reg_sel==LAST_REG go to DONE; otherwise reg_sel <= reg_sel+1 and go to SELECT.
- DONE: done=1 for exactly one cycle, then IDLE. busy and cpu_hold fall on the same edge as the DONE→IDLE transition.
- Timing with tx_ready held at 1:
  - Start is sampled at edge E0. The first tx_valid is visible after E0+2.
  - Per-register period is 2+NBYTES cycles.
  - done is high in the cycle after edge E0 + (LAST_REG-FIRST_REG+1)*(2+NBYTES).
  - Default parameters: done is high in the cycle after E0+224.
- abort:
  - In SELECT or CAPTURE: go to IDLE on the next edge.
  - In SEND: complete the current byte handshake, then go to IDLE without emitting further bytes.
  - Abort never pulses done. abort is ignored in IDLE and DONE.
- start while busy: ignored, no queuing.
- start and abort asserted together in IDLE: start wins; the abort is ignored.
- Register 0 dumps as 0x00000000; this falls out of the register file's behaviour, with no special case here.
- reg_sel increments only within FIRST_REG..LAST_REG and never wraps past 31.
- Async reset mid-SEND drops tx_valid immediately. The sink must tolerate a truncated frame after reset.

Decomposition:
- Shared package dbg_pkg: state enum (IDLE, SELECT, CAPTURE, SEND, DONE), BYTE_W=8, WORD_W=32, REG_IDX_W=5.
- One natural sub-module, word_serializer: loads a 32-bit word plus optional index byte and emits bytes MSB-first under valid/ready. It reports last-byte-accepted to the FSM in rf_dump_reader.

Test Plan:
- Bench register file preloaded r1=0x12345678, r31=0xDEADBEEF, others=i; tx_ready=1; pulse start → 160 bytes. Bytes 0..4 = 00 00 00 00 00. Bytes 5..9 = 01 12 34 56 78. Last 5 bytes = 1F DE AD BE EF. done is high in the cycle after E0+224; busy/cpu_hold then drop.
- Backpressure: tx_ready toggled pseudo-randomly, stuck low for 20 cycles mid-word → identical byte sequence as the no-backpressure case; tx_data and tx_valid unchanged on every stalled cycle; no byte lost or duplicated.
- FIRST_REG=3, LAST_REG=4, SEND_INDEX=0, r3=0xA5A5A5A5, r4=0x0F0F0F0F → exactly 8 bytes A5 A5 A5 A5 0F 0F 0F 0F; done is high in the cycle after E0+12.
- Abort while tx_valid=1 on byte 2 of r5 with tx_ready=0; raise tx_ready after 3 cycles → that byte completes, no further tx_valid, state returns to IDLE, done never pulses.
- start re-pulsed while busy → no restart and byte count unchanged. A second start after done → full repeat dump with identical bytes.
- Async rst asserted mid-SEND → tx_valid, busy, cpu_hold and done go to 0 without waiting for a clock edge; reg_sel=FIRST_REG. A following start produces a clean full dump.
